// File: rtl/dmn_para_ser.sv
// dmn_para_ser: requests a result from the dmn stage, captures it and streams it
// out as a checksummed 15-byte frame over a valid/ready byte link.
module dmn_para_ser #(
    parameter logic [31:0] TIMEOUT = 32'd1000,
    parameter logic [7:0]  HDR     = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        dmn_en,
    input  logic        dmn_end,
    input  logic        zero,
    input  logic [31:0] dmn_para1,
    input  logic [31:0] dmn_para2,
    input  logic [31:0] dmn_para3,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;
    state_t state, state_nxt;
    logic [31:0] cnt, p1, p2, p3;
    logic [3:0] idx;
    logic [7:0] csum;
    logic zero_q, timeout_hit, accept, last;
    logic [14:0][7:0] frame;
    // frame[i] is byte i on the wire; slot 14 carries the running checksum
    always_comb begin
        frame = {csum,
                 p3[7:0], p3[15:8], p3[23:16], p3[31:24],
                 p2[7:0], p2[15:8], p2[23:16], p2[31:24],
                 p1[7:0], p1[15:8], p1[23:16], p1[31:24],
                 7'b0, zero_q, HDR};
        timeout_hit = (TIMEOUT != 32'd0) && (cnt == TIMEOUT - 32'd1);
        accept = (state == SEND) && tx_ready;
        last = accept && (idx == 4'd14);
        dmn_en = state == WAIT;
        tx_valid = state == SEND;
        busy = state != IDLE;
        tx_data = tx_valid ? frame[idx] : 8'h00;
        state_nxt = (state == IDLE) ? (start ? WAIT : IDLE) :
                    (state == WAIT) ? (dmn_end ? SEND : timeout_hit ? IDLE : WAIT) :
                    (last ? IDLE : SEND);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= 32'd0;
            idx <= 4'd0;
            csum <= 8'h00;
            zero_q <= 1'b0;
            p1 <= 32'd0;
            p2 <= 32'd0;
            p3 <= 32'd0;
            done <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= state_nxt;
            done <= (state == WAIT && !dmn_end && timeout_hit) || last;
            if (state == IDLE && start) begin
                err <= 1'b0;
                cnt <= 32'd0;
            end
            if (state == WAIT) begin
                cnt <= cnt + 32'd1;
                if (dmn_end) begin
                    zero_q <= zero;
                    p1 <= dmn_para1;
                    p2 <= dmn_para2;
                    p3 <= dmn_para3;
                    idx <= 4'd0;
                    csum <= 8'h00;
                end else if (timeout_hit) begin
                    err <= 1'b1;
                end
            end
            if (accept) begin
                idx <= last ? idx : idx + 4'd1;
                csum <= csum ^ tx_data;
            end
        end
    end
endmodule

// File: tb/tb_dmn_para_ser.sv
// tb_dmn_para_ser: directed and randomized checks of dmn_para_ser against a
// byte-list frame model.
module tb_dmn_para_ser;
    logic clk, rst_n, start, dmn_en, dmn_end, zero, tx_valid, tx_ready, busy, done, err;
    logic [31:0] dmn_para1, dmn_para2, dmn_para3;
    logic [7:0] tx_data;
    logic tie, end_man;
    logic [7:0] expb [15];
    logic [7:0] got [15];
    int checks = 0;
    int errors = 0;

    assign dmn_end = tie ? dmn_en : end_man;

    dmn_para_ser #(.TIMEOUT(32'd10), .HDR(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dmn_en(dmn_en), .dmn_end(dmn_end),
        .zero(zero), .dmn_para1(dmn_para1), .dmn_para2(dmn_para2), .dmn_para3(dmn_para3),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected frame: header, flag byte, three words MSB first, XOR of all previous bytes.
    function automatic void build(input logic z, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] c);
        logic [31:0] w [3];
        logic [7:0] x;
        w[0] = a;
        w[1] = b;
        w[2] = c;
        expb[0] = 8'hA5;
        expb[1] = {7'b0, z};
        for (int k = 0; k < 12; k++) expb[2 + k] = 8'(w[k / 4] >> (24 - 8 * (k % 4)));
        x = 8'h00;
        for (int k = 0; k < 14; k++) x = x ^ expb[k];
        expb[14] = x;
    endfunction

    task automatic set_params(input logic z, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c);
        zero = z;
        dmn_para1 = a;
        dmn_para2 = b;
        dmn_para3 = c;
        build(z, a, b, c);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    // Runs until done, recording accepted bytes; poke holds start high and scrambles inputs.
    task automatic collect(input string tag, input bit rand_ready, input bit poke, output int ticks);
        int n;
        logic [7:0] prev;
        bit stall;
        n = 0;
        stall = 1'b0;
        prev = 8'h00;
        ticks = 0;
        while (!done && ticks < 300) begin
            if (stall) check({tag, "_stable"}, 32'(tx_data), 32'(prev));
            tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke && tx_valid) begin
                start = 1'b1;
                zero = 1'($urandom);
                dmn_para1 = $urandom;
                dmn_para2 = $urandom;
                dmn_para3 = $urandom;
            end
            stall = tx_valid && !tx_ready;
            prev = tx_data;
            if (tx_valid && tx_ready) begin
                if (n < 15) got[n] = tx_data;
                n++;
            end
            tick;
            ticks++;
        end
        start = 1'b0;
        tx_ready = 1'b1;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_nbytes"}, 32'(n), 32'd15);
        for (int i = 0; i < 15 && i < n; i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(expb[i]));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_valid_at_done"}, 32'(tx_valid), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        tick;
        check({tag, "_done_single"}, 32'(done), 32'd0);
        check({tag, "_idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int t, en_cnt, done_cnt, done_at;
        bit vseen;
        rst_n = 1'b0;
        start = 1'b0;
        tie = 1'b1;
        end_man = 1'b0;
        tx_ready = 1'b1;
        set_params(1'b0, 32'd0, 32'd0, 32'd0);
        tick;
        tick;
        check("rst_dmn_en", 32'(dmn_en), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        rst_n = 1'b1;
        tick;

        // Nominal frame, ready held high: 17 cycles from start to done.
        set_params(1'b0, 32'h00FF9911, 32'd2, 32'd8);
        check("nom_csum_model", 32'(expb[14]), 32'hD8);
        pulse_start;
        check("nom_dmn_en", 32'(dmn_en), 32'd1);
        check("nom_busy", 32'(busy), 32'd1);
        collect("nom", 1'b0, 1'b0, t);
        check("nom_latency", 32'(t + 1), 32'd17);

        // Backpressure with random parameters and random ready.
        for (int r = 0; r < 3; r++) begin
            set_params(1'($urandom), $urandom, $urandom, $urandom);
            pulse_start;
            collect($sformatf("bp%0d", r), 1'b1, 1'b0, t);
        end

        // Timeout with dmn_end stuck low.
        tie = 1'b0;
        end_man = 1'b0;
        pulse_start;
        en_cnt = 0;
        done_cnt = 0;
        done_at = -1;
        vseen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            en_cnt += int'(dmn_en);
            vseen |= tx_valid;
            if (done) begin
                done_cnt++;
                done_at = i;
                check("to_err_at_done", 32'(err), 32'd1);
                check("to_en_at_done", 32'(dmn_en), 32'd0);
            end
            tick;
        end
        check("to_en_cycles", 32'(en_cnt), 32'd10);
        check("to_done_count", 32'(done_cnt), 32'd1);
        check("to_done_cycle", 32'(done_at), 32'd10);
        check("to_no_valid", 32'(vseen), 32'd0);
        check("to_err_sticky", 32'(err), 32'd1);

        // dmn_end first seen in the 10th WAIT cycle beats the timeout.
        set_params(1'($urandom), $urandom, $urandom, $urandom);
        pulse_start;
        check("co_err_cleared", 32'(err), 32'd0);
        for (int i = 0; i < 9; i++) tick;
        check("co_en_cycle10", 32'(dmn_en), 32'd1);
        end_man = 1'b1;
        tick;
        end_man = 1'b0;
        check("co_valid", 32'(tx_valid), 32'd1);
        collect("co", 1'b1, 1'b0, t);

        // Reset while byte 6 is pending.
        tie = 1'b1;
        set_params(1'b0, $urandom, $urandom, $urandom);
        pulse_start;
        for (int i = 0; i < 7; i++) tick;
        check("rm_byte6_pending", 32'(tx_data), 32'(expb[6]));
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        check("rm_valid", 32'(tx_valid), 32'd0);
        check("rm_busy", 32'(busy), 32'd0);
        check("rm_dmn_en", 32'(dmn_en), 32'd0);
        check("rm_tx_data", 32'(tx_data), 32'd0);
        check("rm_err", 32'(err), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            done_cnt += int'(done);
            tick;
        end
        check("rm_no_done", 32'(done_cnt), 32'd0);
        pulse_start;
        collect("rm_after", 1'b0, 1'b0, t);

        // Busy rejection: start pulses in WAIT and SEND, inputs scrambled after capture.
        tie = 1'b0;
        end_man = 1'b0;
        set_params(1'b1, $urandom, $urandom, $urandom);
        pulse_start;
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            tick;
        end
        start = 1'b0;
        check("br_wait_busy", 32'(busy), 32'd1);
        check("br_wait_en", 32'(dmn_en), 32'd1);
        end_man = 1'b1;
        tick;
        end_man = 1'b0;
        collect("br", 1'b1, 1'b1, t);
        vseen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vseen |= tx_valid | busy;
            tick;
        end
        check("br_single_frame", 32'(vseen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
